bcd_convert_seq: RTL and testbench

Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It replaces single-cycle combinational conversion on wide values, so timing closes at system clock. It feeds the frequency/amplitude readout path toward the 7-segment display driver. It adds a start/busy/done handshake, registered outputs held between conversions, overflow saturation, and a leading-zero blank mask.

---
 rtl/bcd_convert_seq_if.sv | 34 +++
 rtl/bcd_convert_seq.sv | 126 ++++++++++++
 tb/tb_bcd_convert_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// Master issues start/bin_val; slave returns status and held results.
interface bcd_convert_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                start;
    logic [BIN_W-1:0]    bin_val;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;
    logic                overflow;

    modport master (
        output start,
        output bin_val,
        input  busy,
        input  done,
        input  bcd,
        input  blank,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_val,
        output busy,
        output done,
        output bcd,
        output blank,
        output overflow
    );
endinterface

// File: rtl/bcd_convert_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter, one bit per clock,
// with saturation on overflow and a leading-zero blank mask.
module bcd_convert_seq #(
    parameter int BIN_W    = 16,
    parameter int DIGITS   = 5,
    parameter bit BLANK_LZ = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    bcd_convert_seq_if.slave bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [ACC_W-1:0] NINES = {DIGITS{4'd9}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [BIN_W-1:0] r_sr;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [ACC_W-1:0] r_bcd;
    logic [DIGITS-1:0] r_blank;
    logic             r_ovf_out;

    logic [ACC_W-1:0] w_adj;
    logic [ACC_W-1:0] w_shift;
    logic             w_carry;
    logic [DIGITS-1:0] w_blank;

    always_comb begin
        w_adj = r_acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_acc[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is the sticky overflow source.
    assign w_shift = {w_adj[ACC_W-2:0], r_sr[BIN_W-1]};
    assign w_carry = w_adj[ACC_W-1];

    always_comb begin
        logic run;
        w_blank = '0;
        run     = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run        = run & (r_acc[4*k +: 4] == 4'd0);
            w_blank[k] = run;
        end
        if (!BLANK_LZ) begin
            w_blank = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_blank   <= '0;
            r_ovf_out <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sr    <= bus.bin_val;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= CNT_W'(BIN_W);
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_shift;
                    r_sr  <= {r_sr[BIN_W-2:0], 1'b0};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_carry) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    if (r_ovf) begin
                        r_bcd     <= NINES;
                        r_blank   <= '0;
                        r_ovf_out <= 1'b1;
                    end else begin
                        r_bcd     <= r_acc;
                        r_blank   <= w_blank;
                        r_ovf_out <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.blank    = r_blank;
    assign bus.overflow = r_ovf_out;
endmodule

// File: tb/tb_bcd_convert_seq.sv
// Bench for bcd_convert_seq: four parameterisations against an arithmetic
// model compared every cycle, plus literal expectations.
module tb_bcd_convert_seq;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bit        s_start [N];
    bit [31:0] s_bin   [N];

    logic        d_busy  [N];
    logic        d_done  [N];
    logic        d_ovf   [N];
    logic [39:0] d_bcd   [N];
    logic [9:0]  d_blank [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_convert_seq_if #(.BIN_W(16), .DIGITS(5)) if0 ();
    bcd_convert_seq_if #(.BIN_W(16), .DIGITS(4)) if1 ();
    bcd_convert_seq_if #(.BIN_W(16), .DIGITS(5)) if2 ();
    bcd_convert_seq_if #(.BIN_W(20), .DIGITS(7)) if3 ();

    bcd_convert_seq #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    bcd_convert_seq #(.BIN_W(16), .DIGITS(4), .BLANK_LZ(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    bcd_convert_seq #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));
    bcd_convert_seq #(.BIN_W(20), .DIGITS(7), .BLANK_LZ(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));

    assign if0.start   = s_start[0];
    assign if1.start   = s_start[1];
    assign if2.start   = s_start[2];
    assign if3.start   = s_start[3];
    assign if0.bin_val = s_bin[0][15:0];
    assign if1.bin_val = s_bin[1][15:0];
    assign if2.bin_val = s_bin[2][15:0];
    assign if3.bin_val = s_bin[3][19:0];

    assign d_busy[0] = if0.busy;
    assign d_busy[1] = if1.busy;
    assign d_busy[2] = if2.busy;
    assign d_busy[3] = if3.busy;
    assign d_done[0] = if0.done;
    assign d_done[1] = if1.done;
    assign d_done[2] = if2.done;
    assign d_done[3] = if3.done;
    assign d_ovf[0]  = if0.overflow;
    assign d_ovf[1]  = if1.overflow;
    assign d_ovf[2]  = if2.overflow;
    assign d_ovf[3]  = if3.overflow;
    assign d_bcd[0]  = 40'(if0.bcd);
    assign d_bcd[1]  = 40'(if1.bcd);
    assign d_bcd[2]  = 40'(if2.bcd);
    assign d_bcd[3]  = 40'(if3.bcd);
    assign d_blank[0] = 10'(if0.blank);
    assign d_blank[1] = 10'(if1.blank);
    assign d_blank[2] = 10'(if2.blank);
    assign d_blank[3] = 10'(if3.blank);

    function automatic int bw(input int id);
        return (id == 3) ? 20 : 16;
    endfunction

    function automatic int dg(input int id);
        case (id)
            1:       return 4;
            3:       return 7;
            default: return 5;
        endcase
    endfunction

    function automatic bit blz(input int id);
        return id != 2;
    endfunction

    function automatic longint pow10(input int d);
        longint p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit exp_ovf(input longint v, input int d);
        return v >= pow10(d);
    endfunction

    function automatic bit [39:0] exp_bcd(input longint v, input int d);
        bit [39:0] r = '0;
        longint t = v;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = exp_ovf(v, d) ? 4'd9 : 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Digit k is a leading zero exactly when the value is below 10^k.
    function automatic bit [9:0] exp_blank(input longint v, input int d,
                                           input bit lz);
        bit [9:0] r = '0;
        if (lz && !exp_ovf(v, d)) begin
            for (int k = 1; k < d; k++) r[k] = (v < pow10(k));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int id,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    // Cycle-level model: busy for BIN_W+1 cycles after an accepted start,
    // then a one-cycle done with results computed arithmetically.
    int        m_cnt   [N];
    bit [31:0] m_val   [N];
    bit        m_done  [N];
    bit        m_ovf   [N];
    bit [39:0] m_bcd   [N];
    bit [9:0]  m_blank [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int id = 0; id < N; id++) begin
                m_cnt[id]   <= 0;
                m_val[id]   <= '0;
                m_done[id]  <= 1'b0;
                m_ovf[id]   <= 1'b0;
                m_bcd[id]   <= '0;
                m_blank[id] <= '0;
            end
        end else begin
            for (int id = 0; id < N; id++) begin
                if (m_cnt[id] == 0) begin
                    m_done[id] <= 1'b0;
                    if (s_start[id]) begin
                        m_val[id] <= s_bin[id] & ((32'd1 << bw(id)) - 32'd1);
                        m_cnt[id] <= bw(id) + 1;
                    end
                end else begin
                    m_cnt[id]  <= m_cnt[id] - 1;
                    m_done[id] <= (m_cnt[id] == 1);
                    if (m_cnt[id] == 1) begin
                        m_bcd[id]   <= exp_bcd(longint'(m_val[id]), dg(id));
                        m_blank[id] <= exp_blank(longint'(m_val[id]), dg(id),
                                                 blz(id));
                        m_ovf[id]   <= exp_ovf(longint'(m_val[id]), dg(id));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int id = 0; id < N; id++) begin
            chk("busy", id, 64'(d_busy[id]), 64'(m_cnt[id] != 0));
            chk("done", id, 64'(d_done[id]), 64'(m_done[id]));
            chk("bcd", id, 64'(d_bcd[id]), 64'(m_bcd[id]));
            chk("blank", id, 64'(d_blank[id]), 64'(m_blank[id]));
            chk("overflow", id, 64'(d_ovf[id]), 64'(m_ovf[id]));
        end
    end

    task automatic run(input int id, input longint v,
                       output logic [39:0] bcd, output logic [9:0] bl,
                       output logic ov, output int lat);
        @(negedge clk);
        s_start[id] = 1'b1;
        s_bin[id]   = 32'(v);
        @(posedge clk);
        #1;
        s_start[id] = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (d_done[id] === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("done_seen", id, 64'(lat > 0), 64'd1);
        bcd = d_bcd[id];
        bl  = d_blank[id];
        ov  = d_ovf[id];
        repeat (2) @(negedge clk);
    endtask

    task automatic lit(input int id, input longint v, input logic [39:0] eb,
                       input logic [9:0] ebl, input logic eo);
        logic [39:0] b;
        logic [9:0]  bl;
        logic        ov;
        int          lat;
        run(id, v, b, bl, ov, lat);
        chk("lit_bcd", id, 64'(b), 64'(eb));
        chk("lit_blank", id, 64'(bl), 64'(ebl));
        chk("lit_ovf", id, 64'(ov), 64'(eo));
    endtask

    initial begin
        logic [39:0] b;
        logic [9:0]  bl;
        logic        ov;
        int          lat;
        int          nd;
        int          nb;

        repeat (3) @(negedge clk);
        chk("rst_busy", 0, 64'(d_busy[0]), 64'd0);
        chk("rst_done", 0, 64'(d_done[0]), 64'd0);
        chk("rst_bcd", 0, 64'(d_bcd[0]), 64'd0);
        chk("rst_blank", 0, 64'(d_blank[0]), 64'd0);
        chk("rst_ovf", 1, 64'(d_ovf[1]), 64'd0);
        rst_n = 1'b1;

        chk("pin_m907", 0, 64'(exp_bcd(907, 5)), 64'h00907);
        chk("pin_mblank907", 0, 64'(exp_blank(907, 5, 1'b1)), 64'b11000);
        chk("pin_movf", 1, 64'(exp_bcd(12345, 4)), 64'h9999);

        run(0, 0, b, bl, ov, lat);
        chk("latency", 0, 64'(lat), 64'd17);
        chk("zero_bcd", 0, 64'(b), 64'h0);
        chk("zero_blank", 0, 64'(bl), 64'b11110);
        chk("zero_ovf", 0, 64'(ov), 64'd0);

        lit(0, 65535, 40'h65535, 10'b0, 1'b0);
        lit(0, 12345, 40'h12345, 10'b0, 1'b0);
        lit(0, 907, 40'h00907, 10'b11000, 1'b0);
        lit(1, 12345, 40'h9999, 10'b0, 1'b1);
        lit(1, 42, 40'h0042, 10'b1100, 1'b0);
        lit(2, 5, 40'h00005, 10'b0, 1'b0);
        lit(3, 1048575, 40'h1048575, 10'b0, 1'b0);
        lit(3, 100, 40'h0000100, 10'b1111000, 1'b0);

        // start held high: accepted only when idle, including done cycles
        nd = 0;
        nb = 0;
        for (int i = 0; i < 73; i++) begin
            @(negedge clk);
            if (i > 0 && d_done[0] === 1'b1) nd++;
            if (i > 0 && d_busy[0] === 1'b1) nb++;
            s_start[0] = 1'b1;
            s_bin[0]   = 32'($urandom_range(0, 65535));
        end
        @(negedge clk);
        s_start[0] = 1'b0;
        chk("held_dones", 0, 64'(nd), 64'd4);
        chk("held_busy", 0, 64'(nb), 64'd68);
        repeat (25) @(negedge clk);

        @(negedge clk);
        s_start[0] = 1'b1;
        s_bin[0]   = 32'd4321;
        @(posedge clk);
        #1;
        s_start[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 0, 64'(d_busy[0]), 64'd0);
        chk("abort_bcd", 0, 64'(d_bcd[0]), 64'd0);
        chk("abort_blank", 0, 64'(d_blank[0]), 64'd0);
        chk("abort_ovf", 1, 64'(d_ovf[1]), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            if (d_done[0] === 1'b1) nd++;
        end
        chk("abort_nodone", 0, 64'(nd), 64'd0);
        lit(0, 4321, 40'h04321, 10'b10000, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            longint v;
            v = longint'($urandom_range(0, 1048575));
            run(3, v, b, bl, ov, lat);
            chk("sweep_bcd", 3, 64'(b), 64'(exp_bcd(v, 7)));
            chk("sweep_ovf", 3, 64'(ov), 64'(v >= 10000000));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
